seg_decode_regbank: RTL and testbench

Parametrised decode-stage register bank for the MIPS pipeline. It combines the register file, which has N_RD read ports and write-first bypass, with load-use hazard detection. A stall FSM holds the front end for a configurable number of cycles. The ID/EX read-data and valid outputs are registered, and the block supports flush. It sits between the IF/ID latch and the execute stage, replacing the fixed two-port register file and single-cycle stall logic.

---
 rtl/seg_decode_regbank.sv | 143 ++++++++++++++
 tb/tb_seg_decode_regbank.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decode_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : seg_decode_regbank
//  Purpose  : Decode-stage register file with N_RD write-first read ports,
//             load-use hazard detection, multi-cycle stall FSM and flush.
//  Options  : DECODE_DEBUG_PORT_EN adds a combinational register dump port.
//  Revision : 1.0
// ============================================================================
module seg_decode_regbank #(
    parameter int LEN          = 32,
    parameter int NB_ADDR      = 5,
    parameter int NB_REG       = 32,
    parameter int N_RD         = 2,
    parameter int STALL_CYCLES = 1
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    input  logic [N_RD*NB_ADDR-1:0]            i_rd_addr,
    input  logic [N_RD-1:0]                    i_rd_use,
    input  logic                               i_RegWrite,
    input  logic [NB_ADDR-1:0]                 i_write_reg,
    input  logic [LEN-1:0]                     i_write_data,
    input  logic                               i_MemRead_ex,
    input  logic [NB_ADDR-1:0]                 i_rt_ex,
    input  logic                               i_flush,
`ifdef DECODE_DEBUG_PORT_EN
    input  logic [NB_ADDR-1:0]                 i_dbg_addr,
    output logic [LEN-1:0]                     o_dbg_data,
`endif
    output logic [N_RD*LEN-1:0]                o_rd_data,
    output logic                               o_valid,
    output logic                               o_stall_flag,
    output logic [$clog2(STALL_CYCLES+1)-1:0]  o_stall_cnt
);

    localparam int                 CNT_W       = $clog2(STALL_CYCLES + 1);
    localparam logic [NB_ADDR:0]   c_REG_LIMIT = (NB_ADDR + 1)'(NB_REG);
    localparam logic [CNT_W-1:0]   c_CNT_LOAD  = CNT_W'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CNT_LAST  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t              r_state_q;
    logic [CNT_W-1:0]    r_cnt_q;
    logic [LEN-1:0]      r_regs_q [NB_REG];
    logic [N_RD*LEN-1:0] r_rd_data_q;
    logic                r_valid_q;

    logic                w_we;
    logic [N_RD-1:0]     w_hit;
    logic                w_hazard;
    logic                w_stall;
    logic [N_RD*LEN-1:0] w_rd_data_d;

    // Register 0 and addresses past the bank are never stored or read back.
    function automatic logic addr_ok(input logic [NB_ADDR-1:0] a);
        return (a != '0) && ({1'b0, a} < c_REG_LIMIT);
    endfunction

    assign w_we = i_RegWrite && addr_ok(i_write_reg);

    generate
        for (genvar k = 0; k < N_RD; k++) begin : g_rd_port
            logic [NB_ADDR-1:0] w_addr;
            logic [LEN-1:0]     w_port_data;

            assign w_addr = i_rd_addr[k*NB_ADDR +: NB_ADDR];

            always_comb begin
                w_port_data = '0;
                if (addr_ok(w_addr)) begin
                    if (w_we && (i_write_reg == w_addr)) begin
                        w_port_data = i_write_data;
                    end else begin
                        w_port_data = r_regs_q[w_addr];
                    end
                end
            end

            assign w_rd_data_d[k*LEN +: LEN] = w_port_data;
            assign w_hit[k] = i_rd_use[k] && (w_addr == i_rt_ex);
        end
    endgenerate

    assign w_hazard = i_valid && i_MemRead_ex && (i_rt_ex != '0) && (|w_hit);
    assign w_stall  = (r_state_q == ST_STALL) || w_hazard;

    assign o_stall_flag = !i_rst && !i_flush && w_stall;
    assign o_stall_cnt  = (r_state_q == ST_STALL) ? r_cnt_q : '0;
    assign o_rd_data    = r_rd_data_q;
    assign o_valid      = r_valid_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NB_REG; i++) begin
                r_regs_q[i] <= '0;
            end
        end else if (w_we) begin
            r_regs_q[i_write_reg] <= i_write_data;
        end
    end

    // Read capture is frozen during a bubble and refreshed on the resume edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= '0;
            r_rd_data_q <= '0;
            r_valid_q   <= 1'b0;
        end else if (i_flush) begin
            r_state_q   <= ST_IDLE;
            r_cnt_q     <= '0;
            r_valid_q   <= 1'b0;
        end else if (r_state_q == ST_STALL) begin
            r_valid_q <= 1'b0;
            if (r_cnt_q == c_CNT_LAST) begin
                r_state_q <= ST_IDLE;
                r_cnt_q   <= '0;
            end else begin
                r_cnt_q   <= r_cnt_q - c_CNT_LAST;
            end
        end else if (w_hazard) begin
            r_valid_q <= 1'b0;
            if (STALL_CYCLES > 1) begin
                r_state_q <= ST_STALL;
                r_cnt_q   <= c_CNT_LOAD;
            end
        end else begin
            r_rd_data_q <= w_rd_data_d;
            r_valid_q   <= i_valid;
        end
    end

`ifdef DECODE_DEBUG_PORT_EN
    assign o_dbg_data = addr_ok(i_dbg_addr) ? r_regs_q[i_dbg_addr] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_decode_regbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_decode_regbank
//  Purpose  : Self-checking bench; two instances (1-cycle stall / 32 regs and
//             3-cycle stall / 24 regs) share stimulus, each with its own model.
//  Revision : 1.0
// ============================================================================
module tb_seg_decode_regbank;

    logic        clk;
    logic        rst, valid, regwrite, memread, flush;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_use;
    logic [4:0]  wr, rt;
    logic [31:0] wdata;

    logic [63:0] data_a, data_b;
    logic        valid_a, valid_b, flag_a, flag_b;
    logic [0:0]  cnt_a;
    logic [1:0]  cnt_b;
`ifdef DECODE_DEBUG_PORT_EN
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_a, dbg_b;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    seg_decode_regbank #(.LEN(32), .NB_ADDR(5), .NB_REG(32), .N_RD(2), .STALL_CYCLES(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rd_addr(rd_addr), .i_rd_use(rd_use),
        .i_RegWrite(regwrite), .i_write_reg(wr), .i_write_data(wdata),
        .i_MemRead_ex(memread), .i_rt_ex(rt), .i_flush(flush),
`ifdef DECODE_DEBUG_PORT_EN
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_a),
`endif
        .o_rd_data(data_a), .o_valid(valid_a), .o_stall_flag(flag_a), .o_stall_cnt(cnt_a)
    );

    seg_decode_regbank #(.LEN(32), .NB_ADDR(5), .NB_REG(24), .N_RD(2), .STALL_CYCLES(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rd_addr(rd_addr), .i_rd_use(rd_use),
        .i_RegWrite(regwrite), .i_write_reg(wr), .i_write_data(wdata),
        .i_MemRead_ex(memread), .i_rt_ex(rt), .i_flush(flush),
`ifdef DECODE_DEBUG_PORT_EN
        .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_b),
`endif
        .o_rd_data(data_b), .o_valid(valid_b), .o_stall_flag(flag_b), .o_stall_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model: per instance, a register array, the number of
    // forced bubble cycles still owed, and the last captured outputs.
    int          m_stall_len [2] = '{1, 3};
    int          m_nreg      [2] = '{32, 24};
    logic [31:0] m_mem  [2][32];
    int          m_busy [2];
    logic        m_valid[2];
    logic [63:0] m_data [2];

    function automatic logic [31:0] m_read(int d, logic [4:0] a);
        if (a == 0 || int'(a) >= m_nreg[d]) return 32'h0;
        return m_mem[d][a];
    endfunction

    function automatic bit m_hazard();
        bit hit0 = rd_use[0] && (rd_addr[4:0] == rt);
        bit hit1 = rd_use[1] && (rd_addr[9:5] == rt);
        return valid && memread && (rt != 0) && (hit0 || hit1);
    endfunction

    function automatic bit m_flag(int d);
        return !rst && !flush && (m_busy[d] > 0 || m_hazard());
    endfunction

    // Advance one clock, update the model with the inputs sampled at that edge.
    task automatic step();
        bit hz;
        @(posedge clk);
        hz = m_hazard();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int i = 0; i < 32; i++) m_mem[d][i] = 32'h0;
                m_busy[d] = 0; m_valid[d] = 1'b0; m_data[d] = 64'h0;
            end else begin
                if (regwrite && wr != 0 && int'(wr) < m_nreg[d]) m_mem[d][wr] = wdata;
                if (flush) begin
                    m_busy[d] = 0; m_valid[d] = 1'b0;
                end else if (m_busy[d] > 0) begin
                    m_busy[d]--; m_valid[d] = 1'b0;
                end else if (hz) begin
                    m_busy[d] = m_stall_len[d] - 1; m_valid[d] = 1'b0;
                end else begin
                    m_data[d]  = {m_read(d, rd_addr[9:5]), m_read(d, rd_addr[4:0])};
                    m_valid[d] = valid;
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; valid = 0; regwrite = 0; memread = 0; flush = 0;
        rd_addr = '0; rd_use = '0; wr = '0; rt = '0; wdata = '0;
`ifdef DECODE_DEBUG_PORT_EN
        dbg_addr = '0;
`endif
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; valid = 1; memread = 1; rt = 5'd3; rd_addr[4:0] = 5'd3; rd_use = 2'b01;
        #1;
        tests_run++;
        if (flag_a !== 1'b0 || flag_b !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flag: got a=%b b=%b want 0", flag_a, flag_b);
        end
        step(); step();
        idle_inputs();
        tests_run++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0) begin
            tests_failed++; $display("FAIL reset_valid: got a=%b b=%b want 0", valid_a, valid_b);
        end
        tests_run++;
        if (data_a !== 64'h0 || data_b !== 64'h0) begin
            tests_failed++; $display("FAIL reset_data: got a=%h b=%h want 0", data_a, data_b);
        end
        tests_run++;
        if (cnt_a !== 1'b0 || cnt_b !== 2'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got a=%0d b=%0d want 0", cnt_a, cnt_b);
        end
    endtask

    task automatic test_writeback();
        idle_inputs();
        regwrite = 1; wr = 5'd2; wdata = 32'h0000abcd;
        step();
        idle_inputs();
        valid = 1; rd_addr[4:0] = 5'd2;
        step();
        tests_run++;
        if (data_a[31:0] !== 32'h0000abcd || valid_a !== 1'b1) begin
            tests_failed++; $display("FAIL wb_read_a: got %h v=%b want 0000abcd v=1", data_a[31:0], valid_a);
        end
        tests_run++;
        if (data_b[31:0] !== 32'h0000abcd) begin
            tests_failed++; $display("FAIL wb_read_b: got %h want 0000abcd", data_b[31:0]);
        end
        idle_inputs();
        valid = 1; regwrite = 1; wr = 5'd0; wdata = 32'hffffffff;
        step();
        idle_inputs();
        valid = 1;
        step();
        tests_run++;
        if (data_a !== 64'h0 || data_b !== 64'h0) begin
            tests_failed++; $display("FAIL reg0_zero: got a=%h b=%h want 0", data_a, data_b);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        valid = 1; regwrite = 1; wr = 5'd8; wdata = 32'h12345678; rd_addr[9:5] = 5'd8;
        step();
        tests_run++;
        if (data_a[63:32] !== 32'h12345678 || valid_a !== 1'b1) begin
            tests_failed++; $display("FAIL bypass: got %h v=%b want 12345678 v=1", data_a[63:32], valid_a);
        end
    endtask

    task automatic test_load_use();
        drain();
        valid = 1; memread = 1; rt = 5'd1; rd_addr[4:0] = 5'd1; rd_use = 2'b01;
        #1;
        tests_run++;
        if (flag_a !== 1'b1) begin
            tests_failed++; $display("FAIL lu_flag_on: got %b want 1", flag_a);
        end
        step();
        memread = 0;
        #1;
        tests_run++;
        if (valid_a !== 1'b0 || flag_a !== 1'b0) begin
            tests_failed++; $display("FAIL lu_bubble: got v=%b flag=%b want v=0 flag=0", valid_a, flag_a);
        end
        step();
        tests_run++;
        if (valid_a !== 1'b1) begin
            tests_failed++; $display("FAIL lu_resume: got v=%b want 1", valid_a);
        end
        drain();
        valid = 1; memread = 1; rt = 5'd1; rd_addr[4:0] = 5'd1; rd_use = 2'b00;
        #1;
        tests_run++;
        if (flag_a !== 1'b0 || flag_b !== 1'b0) begin
            tests_failed++; $display("FAIL lu_unused: got a=%b b=%b want 0", flag_a, flag_b);
        end
        step();
        tests_run++;
        if (valid_a !== 1'b1) begin
            tests_failed++; $display("FAIL lu_unused_valid: got %b want 1", valid_a);
        end
    endtask

    task automatic test_multi_stall();
        logic [1:0] want_cnt [3] = '{2'd0, 2'd2, 2'd1};
        drain();
        valid = 1; memread = 1; rt = 5'd4; rd_addr[9:5] = 5'd4; rd_use = 2'b10;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) memread = 0;
            #1;
            tests_run++;
            if (flag_b !== 1'b1 || cnt_b !== want_cnt[i]) begin
                tests_failed++;
                $display("FAIL ms_cycle%0d: got flag=%b cnt=%0d want flag=1 cnt=%0d", i, flag_b, cnt_b, want_cnt[i]);
            end
            step();
            tests_run++;
            if (valid_b !== 1'b0) begin
                tests_failed++; $display("FAIL ms_bubble%0d: got v=%b want 0", i, valid_b);
            end
        end
        #1;
        tests_run++;
        if (flag_b !== 1'b0 || cnt_b !== 2'd0) begin
            tests_failed++; $display("FAIL ms_end: got flag=%b cnt=%0d want 0 0", flag_b, cnt_b);
        end
    endtask

    task automatic test_flush();
        drain();
        valid = 1; memread = 1; rt = 5'd6; rd_addr[4:0] = 5'd6; rd_use = 2'b01;
        step();
        flush = 1; regwrite = 1; wr = 5'd5; wdata = 32'hdeadbeef;
        #1;
        tests_run++;
        if (flag_b !== 1'b0 || flag_a !== 1'b0) begin
            tests_failed++; $display("FAIL flush_flag: got a=%b b=%b want 0", flag_a, flag_b);
        end
        step();
        idle_inputs();
        valid = 1; rd_addr[4:0] = 5'd5;
        #1;
        tests_run++;
        if (valid_b !== 1'b0 || flag_b !== 1'b0 || cnt_b !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_idle: got v=%b flag=%b cnt=%0d want 0 0 0", valid_b, flag_b, cnt_b);
        end
        step();
        tests_run++;
        if (data_b[31:0] !== 32'hdeadbeef || valid_b !== 1'b1) begin
            tests_failed++; $display("FAIL flush_write: got %h v=%b want deadbeef v=1", data_b[31:0], valid_b);
        end
    endtask

    task automatic test_out_of_range();
        drain();
        regwrite = 1; wr = 5'd28; wdata = 32'h55aa55aa;
        step();
        idle_inputs();
        valid = 1; rd_addr[4:0] = 5'd28;
        step();
        tests_run++;
        if (data_a[31:0] !== 32'h55aa55aa || data_b[31:0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL oor_read: got a=%h b=%h want a=55aa55aa b=0", data_a[31:0], data_b[31:0]);
        end
    endtask

`ifdef DECODE_DEBUG_PORT_EN
    task automatic test_debug();
        drain();
        regwrite = 1; wr = 5'd31; wdata = 32'hcafef00d;
        step();
        idle_inputs();
        dbg_addr = 5'd31;
        #1;
        tests_run++;
        if (dbg_a !== 32'hcafef00d || dbg_b !== 32'h0) begin
            tests_failed++; $display("FAIL dbg_31: got a=%h b=%h want a=cafef00d b=0", dbg_a, dbg_b);
        end
        dbg_addr = 5'd0;
        #1;
        tests_run++;
        if (dbg_a !== 32'h0) begin
            tests_failed++; $display("FAIL dbg_0: got %h want 0", dbg_a);
        end
    endtask
`endif

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(20, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            valid    = ($urandom_range(0, 3) != 0);
            rd_addr  = {rand_addr(), rand_addr()};
            rd_use   = 2'($urandom_range(0, 3));
            regwrite = 1'($urandom_range(0, 1));
            wr       = rand_addr();
            wdata    = $urandom;
            memread  = ($urandom_range(0, 2) == 0);
            rt       = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 19) == 0);
            #1;
            tests_run++;
            if (flag_a !== m_flag(0) || flag_b !== m_flag(1) || cnt_a !== 1'(m_busy[0]) || cnt_b !== 2'(m_busy[1])) begin
                tests_failed++;
                $display("FAIL rnd_comb@%0d: got fa=%b fb=%b ca=%0d cb=%0d want fa=%b fb=%b ca=%0d cb=%0d",
                         n, flag_a, flag_b, cnt_a, cnt_b, m_flag(0), m_flag(1), m_busy[0], m_busy[1]);
            end
            step();
            tests_run++;
            if (valid_a !== m_valid[0] || data_a !== m_data[0] || valid_b !== m_valid[1] || data_b !== m_data[1]) begin
                tests_failed++;
                $display("FAIL rnd_out@%0d: got a=%h/%b b=%h/%b want a=%h/%b b=%h/%b",
                         n, data_a, valid_a, data_b, valid_b, m_data[0], m_valid[0], m_data[1], m_valid[1]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_writeback();
        test_bypass();
        test_load_use();
        test_multi_stall();
        test_flush();
        test_out_of_range();
`ifdef DECODE_DEBUG_PORT_EN
        test_debug();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
